// File: rtl/seg7_scan.sv
// seg7_scan: captures a 16-bit hex word and time-multiplexes it onto a
// 4-digit common-anode 7-segment display. It supports optional
// leading-zero blanking and a decimal-point flash on digit 0 after each load.
module seg7_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned FLASH_SCANS = 50,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int unsigned DIV_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FLASH_W = (FLASH_SCANS > 0) ? $clog2(FLASH_SCANS + 1) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_INIT = FLASH_W'(FLASH_SCANS);
  localparam logic               LZ_EN      = (BLANK_LZ != 0);

  logic [DIV_W-1:0]   divcnt_q, divcnt_d;
  logic [1:0]         idx_q,    idx_d;
  logic [15:0]        shown_q,  shown_d;
  logic [FLASH_W-1:0] flash_q,  flash_d;
  logic [3:0]         an_q,     an_d;
  logic [6:0]         seg_q,    seg_d;
  logic               dp_q,     dp_d;

  logic               tick;
  logic               scan_end;
  logic [3:0]         nibble;
  logic               lz_dark;
  logic               dark;

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-state for scan counters, captured word and dp flash counter
  always_comb begin
    tick     = (divcnt_q == DIV_LAST);
    scan_end = tick && (idx_q == 2'd3);
    divcnt_d = tick ? '0 : divcnt_q + DIV_W'(1);
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    shown_d  = load ? din : shown_q;
    flash_d  = flash_q;
    if (load) begin
      flash_d = FLASH_INIT;
    end else if (scan_end && (flash_q != '0)) begin
      flash_d = flash_q - FLASH_W'(1);
    end
  end

  // Output stage: digit select, decode and blanking for the current slot
  always_comb begin
    nibble  = shown_q[{idx_q, 2'b00} +: 4];
    lz_dark = 1'b0;
    case (idx_q)
      2'd3:    lz_dark = LZ_EN && (shown_q[15:12] == 4'h0);
      2'd2:    lz_dark = LZ_EN && (shown_q[15:8]  == 8'h00);
      2'd1:    lz_dark = LZ_EN && (shown_q[15:4]  == 12'h000);
      default: lz_dark = 1'b0;
    endcase
    dark = !en || lz_dark;
    an_d  = dark ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = dark ? 7'h7F   : hex_decode(nibble);
    dp_d  = !((idx_q == 2'd0) && (flash_q != '0) && en);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      divcnt_q <= '0;
      idx_q    <= 2'd0;
      shown_q  <= 16'h0000;
      flash_q  <= '0;
      an_q     <= 4'b1111;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      divcnt_q <= divcnt_d;
      idx_q    <= idx_d;
      shown_q  <= shown_d;
      flash_q  <= flash_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
